// File: rtl/key_event_arbiter.sv
// rtl/key_event_arbiter.sv - round-robin arbiter sharing one event channel between debounced keys
//
// Purpose: latches per-key press (and optionally release) pulses as pending
// requests and offers them one at a time, round-robin, on a valid/ready port.
// Optional feature macro: KEY_EVT_RELEASE_EN (adds release slots, evt_type=1).
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   key_down   one-cycle press pulses, bit i = key i
//   key_up     one-cycle release pulses (used only with KEY_EVT_RELEASE_EN)
//   evt_valid  event offered
//   evt_ready  consumer accepts when evt_valid && evt_ready
//   evt_key    index of the offered key
//   evt_type   0 = press, 1 = release
//   pending    bit i = key i has any unserved event
//   overflow   sticky: an event was dropped
//   clr_ovf    clears overflow (a simultaneous set wins)
module key_event_arbiter #(
  parameter int N_KEYS = 4,
  parameter int CODE_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_down,
  input  logic [N_KEYS-1:0] key_up,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CODE_W-1:0] evt_key,
  output logic              evt_type,
  output logic [N_KEYS-1:0] pending,
  output logic              overflow,
  input  logic              clr_ovf
);

`ifdef KEY_EVT_RELEASE_EN
  localparam int SLOTS = 2 * N_KEYS;
`else
  localparam int SLOTS = N_KEYS;
`endif
  localparam int SW = $clog2(SLOTS);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t           state;
  logic [SLOTS-1:0] flags;
  logic [SLOTS-1:0] flags_nxt;
  logic [SLOTS-1:0] slot_in;
  logic [SW-1:0]    last_grant;
  logic [SW-1:0]    cur_slot;
  logic [SW-1:0]    pick;
  logic [SW-1:0]    idx;
  logic             found;
  logic             accept;
  logic             hit;
  logic             ovf_set;

  // Slot layout: key i press = slot 2i, release = slot 2i+1 when releases exist.
`ifdef KEY_EVT_RELEASE_EN
  always_comb begin
    slot_in = '0;
    pending = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      slot_in[2*i]   = key_down[i];
      slot_in[2*i+1] = key_up[i];
      pending[i]     = flags[2*i] | flags[2*i+1];
    end
  end
`else
  logic unused_key_up;
  assign unused_key_up = ^key_up;
  assign slot_in       = key_down;
  assign pending       = flags;
`endif

  assign accept = (state == OFFER) && evt_ready;

  // Round-robin search starting just after the last granted slot.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 1; k <= SLOTS; k++) begin
      idx = SW'((int'(last_grant) + k) % SLOTS);
      if (!found && flags[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // A pulse landing in its own slot's accept cycle replaces the served event
  // rather than being dropped; any other pulse into a set flag is an overflow.
  always_comb begin
    flags_nxt = flags;
    ovf_set   = 1'b0;
    hit       = 1'b0;
    for (int s = 0; s < SLOTS; s++) begin
      hit = accept && (cur_slot == SW'(s));
      if (hit) begin
        flags_nxt[s] = slot_in[s];
      end else begin
        flags_nxt[s] = flags[s] | slot_in[s];
        if (slot_in[s] && flags[s]) begin
          ovf_set = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      evt_valid  <= 1'b0;
      evt_key    <= '0;
      evt_type   <= 1'b0;
      flags      <= '0;
      overflow   <= 1'b0;
      last_grant <= SW'(SLOTS - 1);
      cur_slot   <= '0;
    end else begin
      flags    <= flags_nxt;
      overflow <= ovf_set | (overflow & ~clr_ovf);
      case (state)
        IDLE: begin
          if (found) begin
            cur_slot  <= pick;
`ifdef KEY_EVT_RELEASE_EN
            evt_key   <= CODE_W'(pick >> 1);
            evt_type  <= pick[0];
`else
            evt_key   <= CODE_W'(pick);
            evt_type  <= 1'b0;
`endif
            evt_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            last_grant <= cur_slot;
            evt_valid  <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          evt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_arbiter.sv
// tb/tb_key_event_arbiter.sv - scoreboard bench for key_event_arbiter
module tb_key_event_arbiter;
  localparam int N_KEYS = 4;
  localparam int CODE_W = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N_KEYS-1:0] key_down = '0;
  logic [N_KEYS-1:0] key_up = '0;
  logic              evt_valid;
  logic              evt_ready = 1'b0;
  logic [CODE_W-1:0] evt_key;
  logic              evt_type;
  logic [N_KEYS-1:0] pending;
  logic              overflow;
  logic              clr_ovf = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [CODE_W:0] exp_q[$];

  key_event_arbiter #(.N_KEYS(N_KEYS), .CODE_W(CODE_W)) dut (
    .clk(clk), .rst(rst), .key_down(key_down), .key_up(key_up),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_key(evt_key),
    .evt_type(evt_type), .pending(pending), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  // Monitor: every accepted event is checked against the scoreboard.
  always @(negedge clk) begin
    if (!rst && evt_valid && evt_ready) begin
      logic [CODE_W:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL evt_unexpected: got key=%0d type=%0d, expected none", evt_key, evt_type);
      end else begin
        e = exp_q.pop_front();
        if ({evt_type, evt_key} !== e) begin
          errors++;
          $display("FAIL evt_accept: got key=%0d type=%0d, expected key=%0d type=%0d",
                   evt_key, evt_type, e[CODE_W-1:0], e[CODE_W]);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int key, input int typ);
    logic [CODE_W-1:0] k;
    logic              t;
    k = key[CODE_W-1:0];
    t = typ[0];
    exp_q.push_back({t, k});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", evt_valid, 0);
    chk("rst_key", evt_key, 0);
    chk("rst_type", evt_type, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);

    // Single press: pending at t+1, offer at t+2, idle at t+3
    evt_ready = 1'b1;
    key_down = 4'b0010; push_exp(1, 0);
    nxt(); key_down = '0;
    chk("single_pend", pending, 4'b0010);
    chk("single_valid_t1", evt_valid, 0);
    nxt();
    chk("single_valid_t2", evt_valid, 1);
    chk("single_key", evt_key, 1);
    chk("single_type", evt_type, 0);
    nxt();
    chk("single_valid_t3", evt_valid, 0);
    chk("single_pend_t3", pending, 0);

    // Round robin from reset: 0,1,3
    do_reset();
    key_down = 4'b1011; push_exp(0, 0); push_exp(1, 0); push_exp(3, 0);
    nxt(); key_down = '0;
    chk("rr_pend0", pending, 4'b1011);
    nxt(); chk("rr_key0", evt_key, 0);
    nxt(); chk("rr_pend1", pending, 4'b1010);
    nxt(); chk("rr_key1", evt_key, 1);
    nxt(); chk("rr_pend2", pending, 4'b1000);
    nxt(); chk("rr_key3", evt_key, 3);
    nxt(); chk("rr_pend3", pending, 4'b0000);

    // Fairness: after key1, keys 0 and 2 pending -> key2 first
    key_down = 4'b0010; push_exp(1, 0);
    nxt(); key_down = '0;
    nxt();
    key_down = 4'b0101; push_exp(2, 0); push_exp(0, 0);
    nxt(); key_down = '0;
    chk("fair_pend", pending, 4'b0101);
    nxt();
    chk("fair_valid", evt_valid, 1);
    chk("fair_key", evt_key, 2);
    nxt(); nxt();
    chk("fair_key2", evt_key, 0);
    nxt();
    chk("fair_pend_end", pending, 0);

    // Backpressure with key2 held and a repeat pulse
    evt_ready = 1'b0;
    key_down = 4'b0100; push_exp(2, 0); push_exp(0, 0);
    nxt(); key_down = '0;
    nxt();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", evt_valid, 1);
      chk("bp_key", evt_key, 2);
      key_down = (i == 2) ? 4'b0101 : 4'b0000;
      nxt();
    end
    key_down = '0;
    chk("bp_overflow", overflow, 1);
    chk("bp_pend", pending, 4'b0101);
    evt_ready = 1'b1;
    nxt();
    chk("bp_pend_after", pending, 4'b0001);
    nxt();
    chk("bp_key0", evt_key, 0);
    nxt();
    chk("bp_ovf_sticky", overflow, 1);
    clr_ovf = 1'b1;
    nxt(); clr_ovf = 1'b0;
    chk("bp_ovf_clr", overflow, 0);

    // Repulse in the accept cycle of the same slot
    evt_ready = 1'b0;
    key_down = 4'b1000; push_exp(3, 0); push_exp(3, 0);
    nxt(); key_down = '0;
    nxt();
    chk("rep_key", evt_key, 3);
    evt_ready = 1'b1; key_down = 4'b1000;
    nxt(); key_down = '0;
    chk("rep_pend", pending, 4'b1000);
    chk("rep_ovf", overflow, 0);
    chk("rep_valid_gap", evt_valid, 0);
    nxt();
    chk("rep_valid", evt_valid, 1);
    chk("rep_key2", evt_key, 3);
    nxt();
    chk("rep_pend_end", pending, 0);

    // Reset mid-offer, with overflow set and a pulse coincident with rst
    evt_ready = 1'b0;
    key_down = 4'b0110;
    nxt(); key_down = 4'b0010;
    chk("rmo_pend", pending, 4'b0110);
    nxt(); key_down = 4'b1000;
    chk("rmo_valid", evt_valid, 1);
    chk("rmo_key", evt_key, 1);
    chk("rmo_ovf", overflow, 1);
    chk("rmo_pend2", pending, 4'b0110);
    rst = 1'b1;
    nxt(); rst = 1'b0; key_down = '0;
    chk("rmo_valid_after", evt_valid, 0);
    chk("rmo_pend_after", pending, 0);
    chk("rmo_ovf_after", overflow, 0);
    evt_ready = 1'b1;
    key_down = 4'b0001; push_exp(0, 0);
    nxt(); key_down = '0;
    nxt();
    chk("rmo_key0", evt_key, 0);
    nxt();
    chk("rmo_pend_end", pending, 0);

    // Press then release of key1 with the consumer stalled
    evt_ready = 1'b0;
    key_down = 4'b0010;
    nxt(); key_down = '0; key_up = 4'b0010;
    nxt(); key_up = '0;
    chk("rel_valid", evt_valid, 1);
    chk("rel_key", evt_key, 1);
    chk("rel_type", evt_type, 0);
    evt_ready = 1'b1;
    push_exp(1, 0);
`ifdef KEY_EVT_RELEASE_EN
    push_exp(1, 1);
    chk("rel_pend", pending, 4'b0010);
`endif
    nxt(); nxt();
`ifdef KEY_EVT_RELEASE_EN
    chk("rel_valid2", evt_valid, 1);
    chk("rel_key2", evt_key, 1);
    chk("rel_type2", evt_type, 1);
`else
    chk("rel_none", evt_valid, 0);
`endif
    nxt(); nxt();
    chk("rel_pend_end", pending, 0);
    chk("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Shares one event channel between N_KEYS debounced push-buttons.
- Each key is served by its own debouncer. Its one-cycle press pulse, and optionally its release pulse, is latched as a pending request.
- A round-robin arbiter offers one event at a time on a valid/ready port to the downstream LED/mode controller.
- Sits between the per-key debouncers and the consumer logic, replacing the direct pulse-to-toggle wiring.

Parameters:
- N_KEYS, 4, number of key channels (2..16).
- CODE_W, 2, width of key index output; must satisfy 2**CODE_W >= N_KEYS.

Ports:
- clk  in  1  system clock (12 MHz board clock).
- rst  in  1  reset, synchronous, active-high.
- key_down  in  N_KEYS  one-cycle press pulses from the debouncers; bit i = key i.
- key_up  in  N_KEYS  one-cycle release pulses; used only with KEY_EVT_RELEASE_EN.
- evt_valid  out  1  event offered.
- evt_ready  in  1  consumer accepts the event when evt_valid && evt_ready.
- evt_key  out  CODE_W  index of the offered key.
- evt_type  out  1  0 = press, 1 = release.
- pending  out  N_KEYS  bit i = key i has any unserved event.
- overflow  out  1  sticky: an event was dropped.
- clr_ovf  in  1  clears overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high, sampled on posedge clk.
- Reset values:
  - evt_valid=0, evt_key=0, evt_type=0, pending=0, overflow=0.
  - FSM=IDLE.
  - last_grant = last slot, so slot 0 wins first after reset.
- Slots: each key has a press slot. With the feature, it also has a release slot.
  - Slot order is key0 press, key0 release, key1 press, ... (press-only: slot i = key i).
  - Each slot has one pending flag.
- Pending set: a pulse on a slot's input sets its flag at the next edge.
- Pending clear: a flag clears only on acceptance of that slot's event.
- Coalescing and overflow:
  - A pulse arriving while the slot's flag is already set is dropped, and overflow is set.
  - Exception: the accept cycle of that same slot. There the flag stays set (the new event is kept) and overflow is not set.
- Overflow clear: clr_ovf clears overflow. If a set condition occurs in the same cycle, set wins.
- FSM, two states:
  - IDLE: if any flag is set, pick the first set slot searching upward from last_grant+1, wrapping at the slot count. Register evt_key and evt_type, set evt_valid=1, go to OFFER. If no flag is set, stay in IDLE.
  - OFFER: evt_valid=1. evt_key and evt_type are held stable until acceptance, regardless of new pulses.
  - On evt_valid && evt_ready: clear the slot flag (subject to the exception above), set last_grant to that slot, set evt_valid=0, return to IDLE.
- Latency:
  - A pulse in cycle t sets pending at t+1; evt_valid is high at t+2 if the FSM was idle.
  - Maximum throughput is one event per 2 cycles.
- evt_ready is ignored while evt_valid=0.
- pending[i] is the OR of key i's slot flags.
- Reset asserted mid-OFFER abandons the offered event and clears all flags.
- Pulses coincident with rst are discarded.
- Index arithmetic wraps modulo the slot count. No slot index at or above the slot count is ever produced.

Optional Feature:
- Macro: KEY_EVT_RELEASE_EN.
- Defined:
  - Release slots exist; key_up pulses are latched and arbitrated like presses.
  - evt_type=1 for release events.
  - The slot count is 2*N_KEYS.
- Undefined:
  - key_up is ignored; evt_type is tied 0.
  - The slot count is N_KEYS; no release-slot flops exist.

Test Plan:
- Single press: key_down=4'b0010 for 1 cycle at t, evt_ready=1 -> pending[1]=1 at t+1; evt_valid=1, evt_key=1, evt_type=0 at t+2; evt_valid=0 and pending=0 at t+3.
- Round robin: key_down=4'b1011 in one cycle, evt_ready=1 -> accepted keys in order 0,1,3; pending shrinks 1011->1010->1000->0000.
- Next-grant fairness: after a key1 grant, keys 0 and 2 become pending -> next grant is 2.
- Backpressure: hold evt_ready=0 for 10 cycles with key2 offered; pulse key_down[2] and key_down[0] mid-wait:
  - evt_key stays 2 throughout; overflow=1 from the key2 repeat.
  - Key0 is served after evt_ready=1.
  - clr_ovf then gives overflow=0.
- Same-cycle accept and repulse: key_down[3] pulse in key3's accept cycle -> pending[3] stays 1, overflow stays 0, key3 offered again 1 cycle later.
- Reset mid-offer: assert rst while evt_valid=1, pending=4'b0110 -> next cycle evt_valid=0, pending=0, overflow=0; a following key_down[0] yields evt_key=0.
- Release feature, KEY_EVT_RELEASE_EN defined: key_down[1] then key_up[1], consumer stalled -> events delivered as (key1, type 0) then (key1, type 1). Undefined: key_up pulses produce no events.
